// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath: GPR file, special registers, ALU,
// CON flip-flop and an internal word-addressed RAM. Bus sources and register
// loads are driven one-hot by an external control unit each cycle.

// Generic clear/load register used for every datapath register.
module cpu_reg #(
    parameter int W = 32
) (
    input  logic         Clock,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // clr wins over load
    always_ff @(posedge Clock) begin
        if (clr)     q <= '0;
        else if (en) q <= d;
    end
endmodule

module cpu_datapath #(
    parameter int    RAM_DEPTH = 512,
    parameter string RAM_INIT  = ""
) (
    input  logic        Clock,
    input  logic        clr,
    output logic [31:0] Mdatain,
    output logic [31:0] MDR_data_out,
    input  logic        PC_out,
    input  logic        ZHigh_out,
    input  logic        ZLow_out,
    input  logic        HI_out,
    input  logic        LO_out,
    input  logic        C_out,
    input  logic        MDR_out,
    input  logic        MDR_enable,
    input  logic        MAR_enable,
    input  logic        Z_enable,
    input  logic        Y_enable,
    input  logic        PC_enable,
    input  logic        LO_enable,
    input  logic        HI_enable,
    input  logic [31:0] InPort,
    input  logic        IncPC,
    input  logic        Read,
    input  logic [4:0]  opcode,
    input  logic        con_in,
    input  logic        out_port_enable,
    input  logic        RAM_write_enable,
    input  logic        IR_enable,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        R_in,
    input  logic        R_out,
    input  logic        BA_out,
    input  logic        in_port_out,
    input  logic        in_port_enable,
    output logic [31:0] bus_data,
    output logic [31:0] out_port_data,
    output logic        con_out
);
    localparam int NUM_GPR = 16;
    localparam int AW      = $clog2(RAM_DEPTH);

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } z_t;

    typedef logic [31:0] mem_t [RAM_DEPTH];

    logic [31:0] bus;
    logic [NUM_GPR-1:0][31:0] gpr;
    logic [31:0] ir, mar, mdr, mdr_d, y, hi, lo, pc, in_reg, out_reg;
    z_t          z, z_d;
    logic        con_d;

    // ---------------- select/encode ----------------
    logic [3:0]         reg_sel;
    logic [NUM_GPR-1:0] dec, rin, rout;
    logic [31:0]        c_sext, gpr_bus;
    logic               r0_out;

    assign reg_sel = ({4{Gra}} & ir[26:23]) | ({4{Grb}} & ir[22:19]) | ({4{Grc}} & ir[18:15]);
    assign dec     = NUM_GPR'(1) << reg_sel;
    assign rin     = {NUM_GPR{R_in}} & dec;
    assign rout    = {NUM_GPR{R_out | BA_out}} & dec;
    // BA_out reads R0 as zero; only a plain R_out exposes its contents
    assign r0_out  = rout[0] & R_out;
    assign c_sext  = {{13{ir[18]}}, ir[18:0]};

    // ---------------- register file ----------------
    for (genvar i = 0; i < NUM_GPR; i++) begin : g_gpr
        cpu_reg #(.W(32)) u_gpr (.Clock(Clock), .clr(clr), .en(rin[i]), .d(bus), .q(gpr[i]));
    end

    // OR together the GPRs that are driving the bus
    always_comb begin
        gpr_bus = r0_out ? gpr[0] : '0;
        for (int i = 1; i < NUM_GPR; i++)
            if (rout[i]) gpr_bus = gpr_bus | gpr[i];
    end

    // ---------------- special registers ----------------
    assign mdr_d = Read ? Mdatain : bus;

    cpu_reg #(.W(32)) u_ir   (.Clock(Clock), .clr(clr), .en(IR_enable),       .d(bus),    .q(ir));
    cpu_reg #(.W(32)) u_mar  (.Clock(Clock), .clr(clr), .en(MAR_enable),      .d(bus),    .q(mar));
    cpu_reg #(.W(32)) u_mdr  (.Clock(Clock), .clr(clr), .en(MDR_enable),      .d(mdr_d),  .q(mdr));
    cpu_reg #(.W(32)) u_y    (.Clock(Clock), .clr(clr), .en(Y_enable),        .d(bus),    .q(y));
    cpu_reg #(.W(32)) u_hi   (.Clock(Clock), .clr(clr), .en(HI_enable),       .d(bus),    .q(hi));
    cpu_reg #(.W(32)) u_lo   (.Clock(Clock), .clr(clr), .en(LO_enable),       .d(bus),    .q(lo));
    cpu_reg #(.W(32)) u_inp  (.Clock(Clock), .clr(clr), .en(in_port_enable),  .d(InPort), .q(in_reg));
    cpu_reg #(.W(32)) u_outp (.Clock(Clock), .clr(clr), .en(out_port_enable), .d(bus),    .q(out_reg));
    cpu_reg #(.W(64)) u_z    (.Clock(Clock), .clr(clr), .en(Z_enable),        .d(z_d),    .q(z));
    cpu_reg #(.W(1))  u_con  (.Clock(Clock), .clr(clr), .en(con_in),          .d(con_d),  .q(con_out));

    // PC: increment beats a bus load; wraps naturally at 2^32
    always_ff @(posedge Clock) begin
        if (clr)            pc <= '0;
        else if (IncPC)     pc <= pc + 32'd1;
        else if (PC_enable) pc <= bus;
    end

    // ---------------- bus ----------------
    // wired-OR of every enabled source; idle bus reads zero
    always_comb begin
        bus = gpr_bus;
        if (HI_out)      bus = bus | hi;
        if (LO_out)      bus = bus | lo;
        if (ZHigh_out)   bus = bus | z.hi;
        if (ZLow_out)    bus = bus | z.lo;
        if (PC_out)      bus = bus | pc;
        if (MDR_out)     bus = bus | mdr;
        if (in_port_out) bus = bus | in_reg;
        if (C_out)       bus = bus | c_sext;
    end

    // ---------------- CON ----------------
    // condition code lives in IR[20:19]
    always_comb begin
        case (ir[20:19])
            2'b00:   con_d = (bus == '0);
            2'b01:   con_d = (bus != '0);
            2'b10:   con_d = ~bus[31];
            default: con_d = bus[31];
        endcase
    end

    // ---------------- ALU ----------------
    logic [31:0] a, b, quo, rem, sra_r;
    logic [4:0]  sh;
    logic [63:0] rot_r, rot_l, prod;

    assign a     = y;
    assign b     = bus;
    assign sh    = b[4:0];
    assign rot_r = {a, a} >> sh;
    assign rot_l = {a, a} << sh;
    assign sra_r = 32'($signed(a) >>> sh);
    assign prod  = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    // SV signed divide truncates toward zero; remainder takes the dividend's sign
    assign quo   = (b == '0) ? '0 : 32'($signed(a) / $signed(b));
    assign rem   = (b == '0) ? '0 : 32'($signed(a) % $signed(b));

    // operation select; high word stays zero except for mul/div
    always_comb begin
        z_d = '{hi: '0, lo: b};
        case (opcode)
            5'b00011: z_d.lo = a + b;
            5'b00100: z_d.lo = a - b;
            5'b00101: z_d.lo = a & b;
            5'b00110: z_d.lo = a | b;
            5'b00111: z_d.lo = rot_r[31:0];
            5'b01000: z_d.lo = rot_l[63:32];
            5'b01001: z_d.lo = a >> sh;
            5'b01010: z_d.lo = sra_r;
            5'b01011: z_d.lo = a << sh;
            5'b01111: z_d    = '{hi: rem, lo: quo};
            5'b10000: z_d    = prod;
            5'b10001: z_d.lo = 32'd0 - b;
            5'b10010: z_d.lo = ~b;
            default:  z_d.lo = b;
        endcase
    end

    // ---------------- RAM ----------------
    function automatic mem_t mem_load();
        mem_t m;
        foreach (m[i]) m[i] = '0;
        return m;
    endfunction

    mem_t mem = mem_load();

    // synchronous write, untouched by clr
    always_ff @(posedge Clock) begin
        if (RAM_write_enable) mem[mar[AW-1:0]] <= mdr;
    end

    assign Mdatain = mem[mar[AW-1:0]];

    // upper MAR and IR opcode bits have no role in the datapath itself
    logic unused_bits;
    assign unused_bits = ^{mar[31:AW], ir[31:27]};

    assign MDR_data_out  = mdr;
    assign bus_data      = bus;
    assign out_port_data = out_reg;
endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: drives control strobes cycle by cycle,
// queues expected results as stimulus is issued and compares on readout.
module tb_cpu_datapath;
    logic        Clock = 1'b0;
    logic        clr;
    logic [31:0] Mdatain, MDR_data_out, bus_data, out_port_data;
    logic        con_out;
    logic        PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out;
    logic        MDR_enable, MAR_enable, Z_enable, Y_enable, PC_enable, LO_enable, HI_enable;
    logic [31:0] InPort;
    logic        IncPC, Read, con_in, out_port_enable, RAM_write_enable, IR_enable;
    logic [4:0]  opcode;
    logic        Gra, Grb, Grc, R_in, R_out, BA_out, in_port_out, in_port_enable;

    always #5 Clock = ~Clock;

    cpu_datapath dut (
        .Clock(Clock), .clr(clr), .Mdatain(Mdatain), .MDR_data_out(MDR_data_out),
        .PC_out(PC_out), .ZHigh_out(ZHigh_out), .ZLow_out(ZLow_out), .HI_out(HI_out),
        .LO_out(LO_out), .C_out(C_out), .MDR_out(MDR_out), .MDR_enable(MDR_enable),
        .MAR_enable(MAR_enable), .Z_enable(Z_enable), .Y_enable(Y_enable),
        .PC_enable(PC_enable), .LO_enable(LO_enable), .HI_enable(HI_enable),
        .InPort(InPort), .IncPC(IncPC), .Read(Read), .opcode(opcode), .con_in(con_in),
        .out_port_enable(out_port_enable), .RAM_write_enable(RAM_write_enable),
        .IR_enable(IR_enable), .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_in(R_in),
        .R_out(R_out), .BA_out(BA_out), .in_port_out(in_port_out),
        .in_port_enable(in_port_enable), .bus_data(bus_data),
        .out_port_data(out_port_data), .con_out(con_out)
    );

    int          n_err = 0;
    int          n_chk = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    // ALU table: Y = 0xF0000001, bus = 4
    logic [4:0]  ops  [11] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                               5'b01001, 5'b01011, 5'b10001, 5'b10010, 5'b00000};
    logic [31:0] exps [11] = '{32'hF0000005, 32'hEFFFFFFD, 32'h00000000, 32'hF0000005,
                               32'h1F000000, 32'h0000001F, 32'h0F000000, 32'h00000010,
                               32'hFFFFFFFC, 32'hFFFFFFFB, 32'h00000004};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_underflow: got %08h want nothing queued", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            chk(t, obs, e);
        end
    endtask

    task automatic idle();
        {PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out} = '0;
        {MDR_enable, MAR_enable, Z_enable, Y_enable, PC_enable, LO_enable, HI_enable} = '0;
        {IncPC, Read, con_in, out_port_enable, RAM_write_enable, IR_enable} = '0;
        {Gra, Grb, Grc, R_in, R_out, BA_out, in_port_out, in_port_enable} = '0;
        opcode = '0;
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic pop_bus();
        #1;
        sb_pop(bus_data);
        idle();
    endtask

    task automatic inp(input logic [31:0] v);
        InPort = v; in_port_enable = 1'b1; cyc();
    endtask

    task automatic ir_load(input logic [31:0] v);
        inp(v); in_port_out = 1'b1; IR_enable = 1'b1; cyc();
    endtask

    task automatic gpr_load(input logic [3:0] k, input logic [31:0] v);
        ir_load(32'(k) << 23);
        inp(v); in_port_out = 1'b1; Gra = 1'b1; R_in = 1'b1; cyc();
    endtask

    task automatic gpr_look(input logic [3:0] k, input string tag, input logic [31:0] e);
        sb_push(tag, e);
        ir_load(32'(k) << 23);
        Gra = 1'b1; R_out = 1'b1; pop_bus();
    endtask

    task automatic y_load(input logic [31:0] v);
        inp(v); in_port_out = 1'b1; Y_enable = 1'b1; cyc();
    endtask

    task automatic alu(input logic [4:0] op, input logic [31:0] bv);
        inp(bv); in_port_out = 1'b1; opcode = op; Z_enable = 1'b1; cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        idle();
        InPort = '0;
        clr = 1'b1; cyc(); clr = 1'b0;

        // dirty state, then clear it
        gpr_load(4'd5, 32'hDEAD);
        gpr_load(4'd15, 32'hBEEF);
        inp(32'h1234);
        in_port_out = 1'b1; out_port_enable = 1'b1; MDR_enable = 1'b1; PC_enable = 1'b1; cyc();
        con_in = 1'b1; cyc();
        clr = 1'b1; cyc(); clr = 1'b0;
        sb_push("rst_mdr", 0); sb_push("rst_bus", 0); sb_push("rst_outp", 0); sb_push("rst_con", 0);
        #1;
        sb_pop(MDR_data_out); sb_pop(bus_data); sb_pop(out_port_data); sb_pop({31'b0, con_out});
        sb_push("rst_pc", 0); PC_out = 1'b1; pop_bus();
        for (int k = 0; k < 16; k++) gpr_look(4'(k), $sformatf("rst_r%0d", k), 32'h0);

        // memory write / read-back
        inp(32'h10); in_port_out = 1'b1; MAR_enable = 1'b1; cyc();
        inp(32'hCAFE); in_port_out = 1'b1; MDR_enable = 1'b1; cyc();
        sb_push("mdr_bus", 32'hCAFE); #1; sb_pop(MDR_data_out);
        RAM_write_enable = 1'b1; cyc();
        sb_push("mdatain_wr", 32'hCAFE); #1; sb_pop(Mdatain);
        inp(32'h1234); in_port_out = 1'b1; MDR_enable = 1'b1; cyc();
        Read = 1'b1; MDR_enable = 1'b1; cyc();
        sb_push("mdr_ram", 32'hCAFE); #1; sb_pop(MDR_data_out);
        inp(32'h210); in_port_out = 1'b1; MAR_enable = 1'b1; cyc();
        sb_push("mar_hi_ignored", 32'hCAFE); #1; sb_pop(Mdatain);

        // addi R3,R4,-5
        inp(32'h0); in_port_out = 1'b1; MAR_enable = 1'b1; cyc();
        inp(32'h61A7FFFB); in_port_out = 1'b1; MDR_enable = 1'b1; cyc();
        RAM_write_enable = 1'b1; cyc();
        gpr_load(4'd4, 32'h14);
        inp(32'h0); in_port_out = 1'b1; PC_enable = 1'b1; cyc();
        sb_push("addi_r3", 32'h0000000F); sb_push("addi_pc", 32'h1);
        PC_out = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; cyc();
        Read = 1'b1; MDR_enable = 1'b1; cyc();
        MDR_out = 1'b1; IR_enable = 1'b1; cyc();
        Grb = 1'b1; BA_out = 1'b1; Y_enable = 1'b1; cyc();
        C_out = 1'b1; opcode = 5'b00011; Z_enable = 1'b1; cyc();
        ZLow_out = 1'b1; Gra = 1'b1; R_in = 1'b1; cyc();
        Gra = 1'b1; R_out = 1'b1; pop_bus();
        PC_out = 1'b1; pop_bus();

        // R0 under BA_out vs R_out
        gpr_load(4'd0, 32'h55);
        ir_load(32'h0);
        sb_push("ba_r0", 32'h0);    Grb = 1'b1; BA_out = 1'b1; pop_bus();
        sb_push("rout_r0", 32'h55); Grb = 1'b1; R_out = 1'b1;  pop_bus();

        // mul then HI/LO
        y_load(32'hFFFFFFFE);
        alu(5'b10000, 32'd3);
        sb_push("mul_hi", 32'hFFFFFFFF); sb_push("mul_lo", 32'hFFFFFFFA);
        ZHigh_out = 1'b1; HI_enable = 1'b1; cyc();
        ZLow_out = 1'b1; LO_enable = 1'b1; cyc();
        HI_out = 1'b1; pop_bus();
        LO_out = 1'b1; pop_bus();

        // div, divide by zero, shra
        y_load(32'hFFFFFFF9);
        alu(5'b01111, 32'd2);
        sb_push("div_q", 32'hFFFFFFFD); ZLow_out = 1'b1;  pop_bus();
        sb_push("div_r", 32'hFFFFFFFF); ZHigh_out = 1'b1; pop_bus();
        alu(5'b01111, 32'd0);
        sb_push("div0_lo", 32'h0); ZLow_out = 1'b1;  pop_bus();
        sb_push("div0_hi", 32'h0); ZHigh_out = 1'b1; pop_bus();
        y_load(32'h80000000);
        alu(5'b01010, 32'd4);
        sb_push("shra", 32'hF8000000); ZLow_out = 1'b1; pop_bus();

        // remaining ops
        y_load(32'hF0000001);
        for (int i = 0; i < 11; i++) begin
            sb_push($sformatf("alu_op%0d", ops[i]), exps[i]);
            alu(ops[i], 32'd4);
            ZLow_out = 1'b1; pop_bus();
        end
        sb_push("dflt_hi", 32'h0); ZHigh_out = 1'b1; pop_bus();

        // CON
        ir_load(32'h00180000);
        inp(32'h80000001); in_port_out = 1'b1; con_in = 1'b1; cyc();
        sb_push("con11_neg", 32'h1); #1; sb_pop({31'b0, con_out});
        con_in = 1'b1; cyc();
        sb_push("con11_zero", 32'h0); #1; sb_pop({31'b0, con_out});
        ir_load(32'h0);
        inp(32'h5); in_port_out = 1'b1; con_in = 1'b1; cyc();
        sb_push("con00_nz", 32'h0); #1; sb_pop({31'b0, con_out});
        con_in = 1'b1; cyc();
        sb_push("con00_z", 32'h1); #1; sb_pop({31'b0, con_out});

        // PC wrap, IncPC priority, clr during IncPC
        inp(32'hFFFFFFFF); in_port_out = 1'b1; PC_enable = 1'b1; cyc();
        IncPC = 1'b1; cyc();
        sb_push("pc_wrap", 32'h0); PC_out = 1'b1; pop_bus();
        inp(32'h5); in_port_out = 1'b1; PC_enable = 1'b1; cyc();
        inp(32'h100); in_port_out = 1'b1; PC_enable = 1'b1; IncPC = 1'b1; cyc();
        sb_push("pc_inc_prio", 32'h6); PC_out = 1'b1; pop_bus();
        IncPC = 1'b1; Z_enable = 1'b1; clr = 1'b1; cyc(); clr = 1'b0;
        sb_push("pc_clr", 32'h0); PC_out = 1'b1; pop_bus();
        sb_push("ram_keep", 32'h61A7FFFB); #1; sb_pop(Mdatain);
        gpr_look(4'd4, "clr_r4", 32'h0);

        if (exp_q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
